countdown_ctrl: RTL and testbench
=================================

Name: countdown_ctrl

Overview:
- Sequencing controller for the countdown-timer datapath.
- Holds the operator-set duration and the difficulty level.
- Generates the 1 s tick from the 1 kHz system clock and runs the IDLE/RUN/ALARM state machine.
- Drives the remaining-seconds value, display enable, progress-bar pattern and alarm buzzer burst schedule consumed by the 7-seg, LED and dot-matrix drivers.

Parameters:
- TICK_DIV, 1000, clk cycles per 1 s tick (≥2).
- DEF_TENS, 1, reset tens digit of set time (1..9).
- DEF_ONES, 0, reset ones digit of set time (0..9).
- ALARM_BURSTS, 3, number of buzzer bursts in ALARM (1..7).
- BURST_PERIOD, 1000, clk cycles per burst slot.
- BURST_ON, 500, leading cycles of each slot in which the buzzer toggles (< BURST_PERIOD).

Ports:
- clk  in  1  system clock, 1 kHz.
- rst_n  in  1  synchronous active-low reset.
- en  in  1  master enable (slide switch); low forces idle/blank.
- start  in  1  single-cycle debounced pulse: begin countdown.
- stop  in  1  single-cycle pulse: abort/clear to IDLE.
- inc_ones  in  1  pulse: ones digit +1.
- inc_tens  in  1  pulse: tens digit +1.
- level_next  in  1  pulse: level +1.
- set_tens  out  4  tens digit of set time.
- set_ones  out  4  ones digit of set time.
- secs_left  out  7  remaining seconds, binary.
- level  out  2  difficulty level 1..3.
- running  out  1  state==RUN.
- alarm  out  1  state==ALARM.
- tick  out  1  one-cycle 1 s strobe, RUN only.
- disp_en  out  1  7-seg display enable.
- bar  out  8  progress bar, thermometer code from bit 0.
- beep  out  1  buzzer drive.

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE, set_tens=DEF_TENS, set_ones=DEF_ONES, level=1, secs_left=0, tick/running/alarm/beep/disp_en=0, bar=0, all internal counters 0.
- All outputs registered. An input pulse sampled at edge N takes effect at N+1.
- Input priority: !en > stop > start > edits. inc_ones and inc_tens together: both apply.
- en=0: state forced to IDLE, counters cleared, disp_en=0, beep=0, bar=0. Set digits and level are retained. All pulses are ignored.
- Wrap rules:
  - Edits (inc_ones, inc_tens, level_next) are honoured only in IDLE with en=1.
  - ones 9→0.
  - tens 9→1; tens is never 0.
  - level 3→1.
- disp_en: set by any accepted start/edit/level_next pulse; cleared by stop, en=0 or reset.
- set_secs = 10*set_tens+set_ones, range 10..99.
- IDLE:
  - start → RUN.
  - secs_left<=set_secs, tick counter<=0, disp_en<=1.
  - secs_left=0 while IDLE.
- RUN:
  - Tick counter counts 0..TICK_DIV-1. tick=1 in the cycle the counter wraps; the first tick occurs TICK_DIV cycles after entry.
  - On tick, secs_left decrements.
  - Tick with secs_left==1 → secs_left=0 and transition to ALARM in the same cycle.
  - start is ignored. stop → IDLE with secs_left=0.
- ALARM:
  - Phase counter pc counts 0..BURST_PERIOD-1; burst counter counts 0..ALARM_BURSTS-1.
  - beep=1 when pc<BURST_ON and pc is odd, else 0.
  - After the last cycle of burst ALARM_BURSTS-1 → IDLE, beep=0.
  - stop → IDLE immediately, beep=0 on the next cycle.
  - start is ignored.
- bar:
  - IDLE: 0.
  - ALARM: 8'hFF.
  - RUN: lit count k = floor(8*(set_secs-secs_left)/set_secs), bar = (1<<k)-1. Computed with shifts/compares; no free-running divider.
  - set_secs cannot change in RUN because edits are blocked.
- Reset mid-RUN or mid-ALARM returns all reset values on the next edge.

Test Plan:
- Reset check → set_tens=1, set_ones=0, level=1, secs_left=0, bar=0, beep=0, disp_en=0.
- Edit wrap → 10 inc_ones pulses give ones 0→…→9→0; 9 inc_tens pulses from 1 return to 1; 3 level_next pulses return to 1. Same pulses during RUN change nothing.
- TICK_DIV=4, set 1/2 (12 s), start → running=1 and secs_left=12 next cycle. tick every 4 cycles. At secs_left=6, bar=8'h0F. Reaches 0 at cycle 48 with alarm=1 and bar=8'hFF.
- ALARM with BURST_PERIOD=10, BURST_ON=4, ALARM_BURSTS=3 → beep high on pc=1,3 of each slot. Exactly 6 beep pulses, then IDLE after 30 cycles.
- stop at secs_left=5 → IDLE next cycle, secs_left=0, bar=0, disp_en=0; a following start reloads secs_left=12.
- en dropped mid-RUN → IDLE, beep/bar/disp_en=0, digits retained. start while en=0 is ignored.

Source files
------------

// File: rtl/countdown_ctrl.sv
// Sequencing controller for the countdown timer: set-time and level editing,
// 1 s tick generation, IDLE/RUN/ALARM sequencing, progress bar and buzzer bursts.
module countdown_ctrl #(
    parameter int TICK_DIV     = 1000,
    parameter int DEF_TENS     = 1,
    parameter int DEF_ONES     = 0,
    parameter int ALARM_BURSTS = 3,
    parameter int BURST_PERIOD = 1000,
    parameter int BURST_ON     = 500
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       start,
    input  logic       stop,
    input  logic       inc_ones,
    input  logic       inc_tens,
    input  logic       level_next,
    output logic [3:0] set_tens,
    output logic [3:0] set_ones,
    output logic [6:0] secs_left,
    output logic [1:0] level,
    output logic       running,
    output logic       alarm,
    output logic       tick,
    output logic       disp_en,
    output logic [7:0] bar,
    output logic       beep
);

    localparam int TC_W = $clog2(TICK_DIV + 1);
    localparam int PC_W = $clog2(BURST_PERIOD + 1);
    localparam int BC_W = $clog2(ALARM_BURSTS + 1);

    localparam logic [TC_W-1:0] TC_LAST = TC_W'(TICK_DIV - 1);
    localparam logic [PC_W-1:0] PC_LAST = PC_W'(BURST_PERIOD - 1);
    localparam logic [PC_W-1:0] PC_ON   = PC_W'(BURST_ON);
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(ALARM_BURSTS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        ALARM = 2'd2
    } state_t;

    state_t state, state_nx;

    logic [TC_W-1:0] tick_cnt, tick_cnt_nx;
    logic [PC_W-1:0] pc, pc_nx;
    logic [BC_W-1:0] bc, bc_nx;

    logic [6:0] secs_nx;
    logic       tick_nx;
    logic [3:0] tens_nx, ones_nx;
    logic [1:0] level_nx;
    logic       disp_nx;
    logic [7:0] bar_nx;
    logic       beep_nx;

    logic [6:0] set_secs;
    logic [6:0] elapsed;
    logic [9:0] elapsed_x8;
    logic [9:0] set_secs_w;
    logic [7:0] ramp;

    logic start_ok;
    logic edit_ok;
    logic any_edit;

    // 10*tens + ones using shifts only
    assign set_secs = {set_tens, 3'b000} + {2'b00, set_tens, 1'b0} + {3'b000, set_ones};

    assign start_ok = en && !stop && start && (state == IDLE);
    assign edit_ok  = en && !stop && !start && (state == IDLE);
    assign any_edit = inc_ones || inc_tens || level_next;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        secs_nx     = secs_left;
        tick_cnt_nx = tick_cnt;
        tick_nx     = 1'b0;
        pc_nx       = pc;
        bc_nx       = bc;

        if (!en || stop) begin
            state_nx    = IDLE;
            secs_nx     = '0;
            tick_cnt_nx = '0;
            pc_nx       = '0;
            bc_nx       = '0;
        end else begin
            case (state)
                IDLE: begin
                    secs_nx     = '0;
                    tick_cnt_nx = '0;
                    pc_nx       = '0;
                    bc_nx       = '0;
                    if (start) begin
                        state_nx = RUN;
                        secs_nx  = set_secs;
                    end
                end
                RUN: begin
                    if (tick_cnt == TC_LAST) begin
                        tick_cnt_nx = '0;
                        tick_nx     = 1'b1;
                        if (secs_left <= 7'd1) begin
                            secs_nx  = '0;
                            state_nx = ALARM;
                            pc_nx    = '0;
                            bc_nx    = '0;
                        end else begin
                            secs_nx = secs_left - 7'd1;
                        end
                    end else begin
                        tick_cnt_nx = tick_cnt + TC_W'(1);
                    end
                end
                ALARM: begin
                    if (pc == PC_LAST) begin
                        pc_nx = '0;
                        if (bc == BC_LAST) begin
                            state_nx = IDLE;
                            bc_nx    = '0;
                        end else begin
                            bc_nx = bc + BC_W'(1);
                        end
                    end else begin
                        pc_nx = pc + PC_W'(1);
                    end
                end
                default: begin
                    state_nx = IDLE;
                end
            endcase
        end
    end

    // Digits and level are only editable while idle; en=0 freezes them
    always_comb begin
        tens_nx  = set_tens;
        ones_nx  = set_ones;
        level_nx = level;
        if (edit_ok) begin
            if (inc_ones) begin
                ones_nx = (set_ones == 4'd9) ? 4'd0 : set_ones + 4'd1;
            end
            if (inc_tens) begin
                tens_nx = (set_tens == 4'd9) ? 4'd1 : set_tens + 4'd1;
            end
            if (level_next) begin
                level_nx = (level == 2'd3) ? 2'd1 : level + 2'd1;
            end
        end
    end

    always_comb begin
        disp_nx = disp_en;
        if (!en || stop) begin
            disp_nx = 1'b0;
        end else if (start_ok || (edit_ok && any_edit)) begin
            disp_nx = 1'b1;
        end
    end

    // Bar bit i lights once 8*elapsed >= (i+1)*set_secs, giving floor(8*elapsed/set_secs) lit bits
    always_comb begin
        elapsed    = set_secs - secs_nx;
        elapsed_x8 = {elapsed, 3'b000};
        set_secs_w = {3'b000, set_secs};
        ramp       = '0;
        for (int i = 0; i < 8; i++) begin
            ramp[i] = (elapsed_x8 >= set_secs_w * 10'(i + 1));
        end
    end

    always_comb begin
        bar_nx  = 8'h00;
        beep_nx = 1'b0;
        case (state_nx)
            RUN:     bar_nx = ramp;
            ALARM: begin
                bar_nx  = 8'hFF;
                beep_nx = (pc_nx < PC_ON) && pc_nx[0];
            end
            default: bar_nx = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            set_tens  <= 4'(DEF_TENS);
            set_ones  <= 4'(DEF_ONES);
            level     <= 2'd1;
            secs_left <= '0;
            tick_cnt  <= '0;
            pc        <= '0;
            bc        <= '0;
            tick      <= 1'b0;
            running   <= 1'b0;
            alarm     <= 1'b0;
            disp_en   <= 1'b0;
            bar       <= 8'h00;
            beep      <= 1'b0;
        end else begin
            set_tens  <= tens_nx;
            set_ones  <= ones_nx;
            level     <= level_nx;
            secs_left <= secs_nx;
            tick_cnt  <= tick_cnt_nx;
            pc        <= pc_nx;
            bc        <= bc_nx;
            tick      <= tick_nx;
            running   <= (state_nx == RUN);
            alarm     <= (state_nx == ALARM);
            disp_en   <= disp_nx;
            bar       <= bar_nx;
            beep      <= beep_nx;
        end
    end

endmodule

// File: tb/tb_countdown_ctrl.sv
// Self-checking bench for countdown_ctrl: cycle-count model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_countdown_ctrl;

    localparam int TD  = 4;
    localparam int BP  = 10;
    localparam int BON = 4;
    localparam int AB  = 3;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_ALARM = 2;

    localparam logic [4:0] P_START = 5'b10000;
    localparam logic [4:0] P_STOP  = 5'b01000;
    localparam logic [4:0] P_ONES  = 5'b00100;
    localparam logic [4:0] P_TENS  = 5'b00010;
    localparam logic [4:0] P_LVL   = 5'b00001;

    logic       clk = 1'b0;
    logic       rst_n, en, start, stop, inc_ones, inc_tens, level_next;
    logic [3:0] set_tens, set_ones;
    logic [6:0] secs_left;
    logic [1:0] level;
    logic       running, alarm, tick, disp_en, beep;
    logic [7:0] bar;

    int vectors     = 0;
    int miscompares = 0;
    int cycle_no    = 0;
    bit armed       = 1'b0;

    int m_mode, m_cyc, m_tens, m_ones, m_level;
    bit m_disp;

    countdown_ctrl #(
        .TICK_DIV(TD), .DEF_TENS(1), .DEF_ONES(0),
        .ALARM_BURSTS(AB), .BURST_PERIOD(BP), .BURST_ON(BON)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .start(start), .stop(stop),
        .inc_ones(inc_ones), .inc_tens(inc_tens), .level_next(level_next),
        .set_tens(set_tens), .set_ones(set_ones), .secs_left(secs_left),
        .level(level), .running(running), .alarm(alarm), .tick(tick),
        .disp_en(disp_en), .bar(bar), .beep(beep)
    );

    always #5 clk = ~clk;

    function automatic int exp_set_secs();
        return 10 * m_tens + m_ones;
    endfunction

    function automatic int exp_secs();
        if (m_mode == M_RUN) return exp_set_secs() - m_cyc / TD;
        return 0;
    endfunction

    function automatic logic [7:0] exp_bar();
        int s, k;
        if (m_mode == M_ALARM) return 8'hFF;
        if (m_mode != M_RUN) return 8'h00;
        s = exp_set_secs();
        k = (8 * (s - exp_secs())) / s;
        return 8'((1 << k) - 1);
    endfunction

    function automatic logic exp_tick();
        return (m_mode == M_RUN && m_cyc > 0 && (m_cyc % TD) == 0) ||
               (m_mode == M_ALARM && m_cyc == 0);
    endfunction

    function automatic logic exp_beep();
        return (m_mode == M_ALARM) && ((m_cyc % BP) < BON) && (((m_cyc % BP) % 2) == 1);
    endfunction

    // Model: mode plus cycles elapsed in that mode; outputs derived arithmetically
    always @(posedge clk) begin
        cycle_no++;
        if (!rst_n) begin
            armed   = 1'b1;
            m_mode  = M_IDLE;
            m_cyc   = 0;
            m_tens  = 1;
            m_ones  = 0;
            m_level = 1;
            m_disp  = 1'b0;
        end else if (!en || stop) begin
            m_mode = M_IDLE;
            m_cyc  = 0;
            m_disp = 1'b0;
        end else begin
            case (m_mode)
                M_IDLE: begin
                    if (start) begin
                        m_mode = M_RUN;
                        m_cyc  = 0;
                        m_disp = 1'b1;
                    end else if (inc_ones || inc_tens || level_next) begin
                        if (inc_ones)   m_ones  = (m_ones + 1) % 10;
                        if (inc_tens)   m_tens  = (m_tens % 9) + 1;
                        if (level_next) m_level = (m_level % 3) + 1;
                        m_disp = 1'b1;
                    end
                end
                M_RUN: begin
                    m_cyc++;
                    if (m_cyc / TD >= exp_set_secs()) begin
                        m_mode = M_ALARM;
                        m_cyc  = 0;
                    end
                end
                default: begin
                    m_cyc++;
                    if (m_cyc >= BP * AB) begin
                        m_mode = M_IDLE;
                        m_cyc  = 0;
                    end
                end
            endcase
        end
    end

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s at t=%0t: got %0h, expected %0h", name, $time, actual, expected);
        end
    endtask

    always @(negedge clk) begin
        if (armed) begin
            checkOutput("set_tens",  8'(set_tens),  8'(m_tens));
            checkOutput("set_ones",  8'(set_ones),  8'(m_ones));
            checkOutput("level",     8'(level),     8'(m_level));
            checkOutput("secs_left", 8'(secs_left), 8'(exp_secs()));
            checkOutput("running",   8'(running),   8'(m_mode == M_RUN));
            checkOutput("alarm",     8'(alarm),     8'(m_mode == M_ALARM));
            checkOutput("tick",      8'(tick),      8'(exp_tick()));
            checkOutput("disp_en",   8'(disp_en),   8'(m_disp));
            checkOutput("bar",       bar,           exp_bar());
            checkOutput("beep",      8'(beep),      8'(exp_beep()));
        end
    end

    // p = {start, stop, inc_ones, inc_tens, level_next}; returns one cycle after it took effect
    task automatic applyStimulus(input logic [4:0] p);
        @(negedge clk);
        {start, stop, inc_ones, inc_tens, level_next} = p;
        @(negedge clk);
        {start, stop, inc_ones, inc_tens, level_next} = 5'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, %0d vectors", vectors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int t0, beeps, alarm_cycles;
        rst_n = 1'b0;
        en    = 1'b1;
        {start, stop, inc_ones, inc_tens, level_next} = 5'b0;

        repeat (3) @(negedge clk);
        checkOutput("reset set_tens",  8'(set_tens),  8'd1);
        checkOutput("reset set_ones",  8'(set_ones),  8'd0);
        checkOutput("reset level",     8'(level),     8'd1);
        checkOutput("reset secs_left", 8'(secs_left), 8'd0);
        checkOutput("reset bar",       bar,           8'h00);
        checkOutput("reset beep",      8'(beep),      8'd0);
        checkOutput("reset disp_en",   8'(disp_en),   8'd0);
        rst_n = 1'b1;

        for (int i = 1; i <= 10; i++) begin
            applyStimulus(P_ONES);
            if (i == 9) checkOutput("ones reaches 9", 8'(set_ones), 8'd9);
        end
        checkOutput("ones wraps to 0", 8'(set_ones), 8'd0);
        for (int i = 1; i <= 9; i++) begin
            applyStimulus(P_TENS);
            if (i == 8) checkOutput("tens reaches 9", 8'(set_tens), 8'd9);
        end
        checkOutput("tens wraps to 1", 8'(set_tens), 8'd1);
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(P_LVL);
            if (i == 2) checkOutput("level reaches 3", 8'(level), 8'd3);
        end
        checkOutput("level wraps to 1", 8'(level), 8'd1);
        checkOutput("disp_en after edits", 8'(disp_en), 8'd1);

        applyStimulus(P_ONES);
        applyStimulus(P_ONES);
        checkOutput("ones set to 2", 8'(set_ones), 8'd2);

        applyStimulus(P_START);
        t0 = cycle_no;
        checkOutput("start running", 8'(running),   8'd1);
        checkOutput("start secs",    8'(secs_left), 8'd12);
        checkOutput("start bar",     bar,           8'h00);

        applyStimulus(P_ONES);
        applyStimulus(P_TENS);
        applyStimulus(P_LVL);
        applyStimulus(P_START);
        checkOutput("run edit ones",  8'(set_ones), 8'd2);
        checkOutput("run edit tens",  8'(set_tens), 8'd1);
        checkOutput("run edit level", 8'(level),    8'd1);

        for (int i = 0; i < 100 && secs_left != 7'd6; i++) @(negedge clk);
        checkOutput("reached secs 6", 8'(secs_left), 8'd6);
        checkOutput("bar at secs 6",  bar,           8'h0F);

        for (int i = 0; i < 100 && alarm !== 1'b1; i++) @(negedge clk);
        checkOutput("alarm reached",   8'(alarm),        8'd1);
        checkOutput("cycles to alarm", 8'(cycle_no - t0), 8'd48);
        checkOutput("alarm secs",      8'(secs_left),    8'd0);
        checkOutput("alarm bar",       bar,              8'hFF);

        beeps = 0;
        alarm_cycles = 0;
        for (int i = 0; i < 100 && alarm === 1'b1; i++) begin
            alarm_cycles++;
            if (beep === 1'b1) beeps++;
            @(negedge clk);
        end
        checkOutput("beep pulses",   8'(beeps),        8'd6);
        checkOutput("alarm length",  8'(alarm_cycles), 8'd30);
        checkOutput("idle after alarm", 8'(alarm),     8'd0);

        applyStimulus(P_START);
        for (int i = 0; i < 100 && secs_left != 7'd5; i++) @(negedge clk);
        checkOutput("reached secs 5", 8'(secs_left), 8'd5);
        applyStimulus(P_STOP);
        checkOutput("stop running", 8'(running),   8'd0);
        checkOutput("stop secs",    8'(secs_left), 8'd0);
        checkOutput("stop bar",     bar,           8'h00);
        checkOutput("stop disp_en", 8'(disp_en),   8'd0);
        applyStimulus(P_START);
        checkOutput("restart secs",    8'(secs_left), 8'd12);
        checkOutput("restart running", 8'(running),   8'd1);

        repeat (6) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        checkOutput("en0 running", 8'(running),  8'd0);
        checkOutput("en0 bar",     bar,          8'h00);
        checkOutput("en0 disp_en", 8'(disp_en),  8'd0);
        checkOutput("en0 beep",    8'(beep),     8'd0);
        checkOutput("en0 tens",    8'(set_tens), 8'd1);
        checkOutput("en0 ones",    8'(set_ones), 8'd2);
        applyStimulus(P_START);
        checkOutput("en0 start ignored", 8'(running), 8'd0);
        applyStimulus(P_ONES);
        checkOutput("en0 edit ignored", 8'(set_ones), 8'd2);
        en = 1'b1;

        applyStimulus(P_START);
        for (int i = 0; i < 100 && alarm !== 1'b1; i++) @(negedge clk);
        checkOutput("second alarm", 8'(alarm), 8'd1);
        repeat (2) @(negedge clk);
        applyStimulus(P_STOP);
        checkOutput("alarm stop alarm", 8'(alarm), 8'd0);
        checkOutput("alarm stop beep",  8'(beep),  8'd0);
        checkOutput("alarm stop bar",   bar,       8'h00);

        applyStimulus(P_START);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("midrun reset ones",    8'(set_ones),  8'd0);
        checkOutput("midrun reset running", 8'(running),   8'd0);
        checkOutput("midrun reset secs",    8'(secs_left), 8'd0);
        checkOutput("midrun reset disp_en", 8'(disp_en),   8'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
